sysarr_lock_arbiter: RTL and testbench

Two-requester lock arbiter and launch sequencer for the systolic array. It sits between the thread blocks and `sys_array_controller`, with one independent channel for the load (B) path and one for the compute (A/D/C) path. Each channel grants the resource round-robin and latches the winner's operand addresses. It issues a single start pulse to the array controller and holds the lock until the controller reports completion.

---
 rtl/sysarr_pkg.sv | 20 ++
 rtl/sysarr_lock_channel.sv | 98 +++++++++
 rtl/sysarr_lock_arbiter.sv | 77 +++++++
 tb/tb_sysarr_lock_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// Shared types for the systolic-array lock arbiter: channel state encoding,
// thread count and the round-robin pick helper.
package sysarr_pkg;

   localparam int NTHREADS = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // Two-thread round robin: on a tie the thread not granted last wins.
   function automatic logic rr_pick(input logic [NTHREADS-1:0] req, input logic last);
      if (req[0] && req[1]) return ~last;
      return req[1];
   endfunction

endpackage

// File: rtl/sysarr_lock_channel.sv
// One lock channel: round-robin grant, operand latch, start pulse, hold until finish.
// Optional BUSY watchdog enabled by SYSARR_ARB_TIMEOUT_EN.
//
// Handshake: a requester holds lock_req[i] high; the channel answers with a
// one-hot lock_res and a one-cycle start, then holds the grant until a
// finished pulse arrives in BUSY (finished in any other state is ignored).
module sysarr_lock_channel
   import sysarr_pkg::*;
#(
   parameter int W              = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NTHREADS-1:0]   lock_req,
   input  logic [NTHREADS*W-1:0] addr_in,
   input  logic                  finished,
   output logic [NTHREADS-1:0]   lock_res,
   output logic                  start,
   output logic [W-1:0]          addr,
   output logic                  timeout_err,
   output arb_state_t            state
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic last;
   logic owner;
   logic win;

   assign win = rr_pick(lock_req, last);

`ifdef SYSARR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] busy_cnt;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         owner    <= 1'b0;
         lock_res <= '0;
         start    <= 1'b0;
         addr     <= '0;
`ifdef SYSARR_ARB_TIMEOUT_EN
         busy_cnt    <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         start <= 1'b0;
         case (state)
            IDLE: begin
               if (|lock_req) begin
                  owner    <= win;
                  lock_res <= {win, ~win};
                  addr     <= win ? addr_in[2*W-1:W] : addr_in[W-1:0];
                  start    <= 1'b1;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               state <= BUSY;
`ifdef SYSARR_ARB_TIMEOUT_EN
               busy_cnt <= '0;
`endif
            end
            BUSY: begin
               if (finished) begin
                  lock_res <= '0;
                  last     <= owner;
                  state    <= RELEASE;
               end
`ifdef SYSARR_ARB_TIMEOUT_EN
               // busy_cnt counts completed BUSY cycles; this one is the last allowed.
               else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  lock_res    <= '0;
                  last        <= owner;
                  timeout_err <= 1'b1;
                  state       <= RELEASE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
`endif
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYSARR_ARB_TIMEOUT_EN
   assign timeout_err = 1'b0;
`endif

endmodule

// File: rtl/sysarr_lock_arbiter.sv
// Two-requester lock arbiter for the systolic array: independent load (B) and
// compute (A/D/C) channels. Watchdog enabled by SYSARR_ARB_TIMEOUT_EN.
module sysarr_lock_arbiter
   import sysarr_pkg::*;
#(
   parameter int BITWIDTH       = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            comp_lock_req,
   input  logic [2*BITWIDTH-1:0] A_addr_in,
   input  logic [2*BITWIDTH-1:0] D_addr_in,
   input  logic [2*BITWIDTH-1:0] C_addr_in,
   output logic [1:0]            comp_lock_res,
   output logic                  comp_start,
   output logic [BITWIDTH-1:0]   A_addr,
   output logic [BITWIDTH-1:0]   D_addr,
   output logic [BITWIDTH-1:0]   C_addr,
   input  logic                  comp_finished,
   input  logic [1:0]            load_lock_req,
   input  logic [2*BITWIDTH-1:0] B_addr_in,
   output logic [1:0]            load_lock_res,
   output logic                  load_start,
   output logic [BITWIDTH-1:0]   B_addr,
   input  logic                  load_finished,
   output logic [1:0]            timeout_err,
   output arb_state_t            comp_state,
   output arb_state_t            load_state
);

   localparam int B = BITWIDTH;

   logic [2*3*B-1:0] comp_bundle;
   logic [3*B-1:0]   comp_addr;
   logic             comp_err;
   logic             load_err;

   // Per-thread compute bundle is {A, D, C}; thread 1 in the upper half.
   assign comp_bundle = {A_addr_in[2*B-1:B], D_addr_in[2*B-1:B], C_addr_in[2*B-1:B],
                         A_addr_in[B-1:0],   D_addr_in[B-1:0],   C_addr_in[B-1:0]};
   assign {A_addr, D_addr, C_addr} = comp_addr;
   assign timeout_err = {comp_err, load_err};

   sysarr_lock_channel #(
      .W              (3*B),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_comp (
      .clock       (clock),
      .reset       (reset),
      .lock_req    (comp_lock_req),
      .addr_in     (comp_bundle),
      .finished    (comp_finished),
      .lock_res    (comp_lock_res),
      .start       (comp_start),
      .addr        (comp_addr),
      .timeout_err (comp_err),
      .state       (comp_state)
   );

   sysarr_lock_channel #(
      .W              (B),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_load (
      .clock       (clock),
      .reset       (reset),
      .lock_req    (load_lock_req),
      .addr_in     (B_addr_in),
      .finished    (load_finished),
      .lock_res    (load_lock_res),
      .start       (load_start),
      .addr        (B_addr),
      .timeout_err (load_err),
      .state       (load_state)
   );

endmodule

// File: tb/tb_sysarr_lock_arbiter.sv
// Self-checking bench for sysarr_lock_arbiter: directed scenarios plus random
// traffic, all checked against a transaction-timing reference model.
module tb_sysarr_lock_arbiter;
   import sysarr_pkg::*;

   localparam int BW = 32;
   localparam int TO = 8;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [1:0]      comp_lock_req = '0, load_lock_req = '0;
   logic [2*BW-1:0] A_addr_in = '0, D_addr_in = '0, C_addr_in = '0, B_addr_in = '0;
   logic            comp_finished = 1'b0, load_finished = 1'b0;
   logic [1:0]      comp_lock_res, load_lock_res, timeout_err;
   logic            comp_start, load_start;
   logic [BW-1:0]   A_addr, D_addr, C_addr, B_addr;
   arb_state_t      comp_state, load_state;

   sysarr_lock_arbiter #(.BITWIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .comp_lock_req(comp_lock_req), .A_addr_in(A_addr_in), .D_addr_in(D_addr_in),
      .C_addr_in(C_addr_in), .comp_lock_res(comp_lock_res), .comp_start(comp_start),
      .A_addr(A_addr), .D_addr(D_addr), .C_addr(C_addr), .comp_finished(comp_finished),
      .load_lock_req(load_lock_req), .B_addr_in(B_addr_in), .load_lock_res(load_lock_res),
      .load_start(load_start), .B_addr(B_addr), .load_finished(load_finished),
      .timeout_err(timeout_err), .comp_state(comp_state), .load_state(load_state)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model, per channel (0 = load, 1 = compute): who holds the lock,
   // at which edge it was granted, and the first edge a new grant may happen.
   int             m_owner[2];
   int             m_last[2];
   int             m_grant[2];
   int             m_free[2];
   logic [3*BW-1:0] m_addr[2];
   logic           m_err[2];

   // scoreboard of expected load grant order under contention
   logic [1:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         m_owner[ch] = -1;
         m_last[ch]  = 1;
         m_grant[ch] = 0;
         m_free[ch]  = cyc + 1;
         m_addr[ch]  = '0;
         m_err[ch]   = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic [1:0] rq;
      logic       fn;
      int         w;
      for (int ch = 0; ch < 2; ch++) begin
         rq = (ch == 1) ? comp_lock_req : load_lock_req;
         fn = (ch == 1) ? comp_finished : load_finished;
         if (m_owner[ch] < 0) begin
            if (cyc >= m_free[ch] && rq != 2'b00) begin
               if (rq == 2'b11) w = 1 - m_last[ch];
               else             w = rq[1] ? 1 : 0;
               m_owner[ch] = w;
               m_grant[ch] = cyc;
               if (ch == 1)
                  m_addr[ch] = {A_addr_in[w*BW +: BW], D_addr_in[w*BW +: BW], C_addr_in[w*BW +: BW]};
               else begin
                  m_addr[ch] = '0;
                  m_addr[ch][BW-1:0] = B_addr_in[w*BW +: BW];
               end
            end
         end else if (cyc >= m_grant[ch] + 2) begin
            // finish honoured only once the launch cycle is over
            if (fn) begin
               m_last[ch]  = m_owner[ch];
               m_owner[ch] = -1;
               m_free[ch]  = cyc + 2;
            end
`ifdef SYSARR_ARB_TIMEOUT_EN
            else if (cyc == m_grant[ch] + 1 + TO) begin
               m_err[ch]   = 1'b1;
               m_last[ch]  = m_owner[ch];
               m_owner[ch] = -1;
               m_free[ch]  = cyc + 2;
            end
`endif
         end
      end
   endtask

   function automatic logic [1:0] exp_res(input int ch);
      if (m_owner[ch] < 0) return 2'b00;
      return (m_owner[ch] == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic exp_start(input int ch);
      return (m_owner[ch] >= 0) && (m_grant[ch] == cyc);
   endfunction

   task automatic compare_all();
      check("load_res",    load_lock_res, exp_res(0));
      check("load_start",  load_start,    exp_start(0));
      check("B_addr",      B_addr,        m_addr[0][BW-1:0]);
      check("comp_res",    comp_lock_res, exp_res(1));
      check("comp_start",  comp_start,    exp_start(1));
      check("ADC_addr",    {A_addr, D_addr, C_addr}, m_addr[1]);
      check("timeout_err", timeout_err,   {m_err[1], m_err[0]});
   endtask

   // driver: inputs are already set; advance one edge, update model, compare
   task automatic step();
      @(posedge clock);
      cyc++;
      if (reset) model_reset();
      else       model_edge();
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fin_edge;
      int cd;
      int grants;

      // reset state
      reset = 1'b1;
      steps(2);
      check("rst_comp_state", comp_state, IDLE);
      check("rst_load_state", load_state, IDLE);
      reset = 1'b0;
      step();

      // thread 0 only, late address change, finish after 5 cycles
      A_addr_in = {32'h0, 32'h10};
      D_addr_in = {32'h0, 32'h20};
      C_addr_in = {32'h0, 32'h30};
      comp_lock_req = 2'b01;
      step();
      check("t0_grant", comp_lock_res, 2'b01);
      check("t0_start", comp_start, 1'b1);
      check("t0_A", A_addr, 32'h10);
      step();
      check("t0_start_once", comp_start, 1'b0);
      A_addr_in[BW-1:0] = 32'h99;
      steps(3);
      comp_finished = 1'b1;
      step();
      comp_finished = 1'b0;
      comp_lock_req = 2'b00;
      check("t0_release", comp_lock_res, 2'b00);
      check("t0_late_addr", A_addr, 32'h10);

      // stray finish pulses in RELEASE / IDLE
      comp_finished = 1'b1;
      steps(3);
      comp_finished = 1'b0;
      check("stray_finish", comp_lock_res, 2'b00);

      // load contention: grants 01, 10, 01 with regrant 3 cycles after finish
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b01);
      load_lock_req = 2'b11;
      fin_edge = -1;
      cd = -1;
      grants = 0;
      for (int i = 0; i < 60 && grants < 3; i++) begin
         load_finished = (cd == 0);
         if (cd == 0) fin_edge = cyc + 1;
         if (cd >= 0) cd--;
         step();
         if (load_start) begin
            grants++;
            if (exp_q.size() > 0) check("load_order", load_lock_res, exp_q.pop_front());
            // finish driven after edge fin_edge-1; grant must follow 3 edges later
            if (fin_edge >= 0) check("load_regrant_gap", cyc - (fin_edge - 1), 3);
            cd = 3;
         end
      end
      load_finished = 1'b0;
      check("load_grants", grants, 3);
      load_lock_req = 2'b00;
      steps(2);
      load_finished = 1'b1;
      step();
      load_finished = 1'b0;
      steps(3);

      // concurrent channels
      comp_lock_req = 2'b01;
      load_lock_req = 2'b10;
      step();
      check("conc_comp", comp_lock_res, 2'b01);
      check("conc_load", load_lock_res, 2'b10);
      steps(2);
      comp_finished = 1'b1;
      step();
      comp_finished = 1'b0;
      comp_lock_req = 2'b00;
      check("conc_comp_rel", comp_lock_res, 2'b00);
      check("conc_load_held", load_lock_res, 2'b10);
      steps(2);
      load_finished = 1'b1;
      step();
      load_finished = 1'b0;
      load_lock_req = 2'b00;
      check("conc_load_rel", load_lock_res, 2'b00);
      steps(3);

      // reset mid-BUSY
      comp_lock_req = 2'b10;
      steps(3);
      reset = 1'b1;
      step();
      check("rst_mid_res", comp_lock_res, 2'b00);
      check("rst_mid_start", comp_start, 1'b0);
      check("rst_mid_A", A_addr, 32'h0);
      reset = 1'b0;
      comp_lock_req = 2'b11;
      step();
      check("post_rst_grant", comp_lock_res, 2'b01);
      comp_lock_req = 2'b00;
      steps(2);
      comp_finished = 1'b1;
      step();
      comp_finished = 1'b0;
      steps(3);

`ifdef SYSARR_ARB_TIMEOUT_EN
      // watchdog: grant with no finish
      comp_lock_req = 2'b01;
      step();
      comp_lock_req = 2'b00;
      steps(TO + 1);
      check("to_flag", timeout_err[1], 1'b1);
      check("to_res", comp_lock_res, 2'b00);
      steps(5);
      check("to_sticky", timeout_err[1], 1'b1);
      reset = 1'b1;
      step();
      check("to_cleared", timeout_err, 2'b00);
      reset = 1'b0;
      step();
`endif

      // random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         comp_lock_req = 2'($urandom_range(0, 3));
         load_lock_req = 2'($urandom_range(0, 3));
         comp_finished = ($urandom_range(0, 3) == 0);
         load_finished = ($urandom_range(0, 3) == 0);
         A_addr_in = {$urandom(), $urandom()};
         D_addr_in = {$urandom(), $urandom()};
         C_addr_in = {$urandom(), $urandom()};
         B_addr_in = {$urandom(), $urandom()};
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
